// File: rtl/bp_pkg.sv
// Shared definitions for the branch prediction table: counter reset and
// saturation values, plus the PC/history index hash.
package bp_pkg;

  // Widest index the table supports (256 entries).
  localparam int unsigned IDX_MAX_W = 8;

  // Weakly-not-taken: MSB clear, all lower bits set.
  function automatic int unsigned cnt_reset_val(input int unsigned cnt_w);
    return (32'd1 << (cnt_w - 32'd1)) - 32'd1;
  endfunction

  // Strongly-taken ceiling of a cnt_w-bit saturating counter.
  function automatic int unsigned cnt_sat_max(input int unsigned cnt_w);
    return (32'd1 << cnt_w) - 32'd1;
  endfunction

  // gshare hash: word-aligned PC bits XOR zero-extended history, masked
  // down to the table index width.
  function automatic logic [IDX_MAX_W-1:0] idx_hash(
    input logic [IDX_MAX_W-1:0] pc_word,
    input logic [IDX_MAX_W-1:0] ghr,
    input int unsigned          idx_w
  );
    logic [IDX_MAX_W-1:0] mask;
    mask = IDX_MAX_W'((32'd1 << idx_w) - 32'd1);
    return (pc_word ^ ghr) & mask;
  endfunction

endpackage

// File: rtl/bp_sat_counter.sv
// One saturating up/down counter of the prediction table. The MSB is the
// predicted direction.
module bp_sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CNT_W = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic i_upd_en,
  input  logic i_upd_taken,
  output logic o_taken
);

  localparam logic [CNT_W-1:0] RST_VAL = CNT_W'(cnt_reset_val(CNT_W));
  localparam logic [CNT_W-1:0] MAX_VAL = CNT_W'(cnt_sat_max(CNT_W));

  logic [CNT_W-1:0] r_cnt;

  // Step toward the resolved outcome, holding at either end instead of wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_cnt <= RST_VAL;
    end else if (i_upd_en) begin
      if (i_upd_taken) begin
        if (r_cnt != MAX_VAL) r_cnt <= r_cnt + CNT_W'(1);
      end else begin
        if (r_cnt != '0) r_cnt <= r_cnt - CNT_W'(1);
      end
    end
  end

  assign o_taken = r_cnt[CNT_W-1];

endmodule

// File: rtl/branch_predict_table.sv
// Table of saturating counters indexed by PC, optionally XOR-hashed with a
// speculative global history (gshare). One lookup and one update per cycle.
//
// Interface semantics: pred_valid and upd_valid are single-cycle strobes with
// no back-pressure (there is no ready); each asserted cycle is exactly one
// lookup or one update. pred_out_valid is high for exactly one cycle, the
// cycle after a lookup, and qualifies pred_taken and pred_ghr.
module branch_predict_table
  import bp_pkg::*;
#(
  parameter  int unsigned ENTRIES = 64,
  parameter  int unsigned CNT_W   = 2,
  parameter  int unsigned GHR_W   = 4,
  parameter  int unsigned PC_W    = 32,
  localparam int unsigned IDX_W   = $clog2(ENTRIES),
  localparam int unsigned GHR_WE  = (GHR_W > 0) ? GHR_W : 1
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              pred_valid,
  input  logic [PC_W-1:0]   pred_pc,
  output logic              pred_taken,
  output logic              pred_out_valid,
  output logic [GHR_WE-1:0] pred_ghr,
  input  logic              upd_valid,
  input  logic [PC_W-1:0]   upd_pc,
  input  logic [GHR_WE-1:0] upd_ghr,
  input  logic              upd_taken,
  input  logic              upd_mispredict
);

  // Elaboration-time parameter legality.
  if (ENTRIES < 4 || ENTRIES > 256 || (ENTRIES & (ENTRIES - 1)) != 0) begin : g_bad_entries
    $error("branch_predict_table: ENTRIES must be a power of two in 4..256");
  end
  if (CNT_W < 2 || CNT_W > 4) begin : g_bad_cnt_w
    $error("branch_predict_table: CNT_W must be in 2..4");
  end
  if (GHR_W > IDX_W) begin : g_bad_ghr_w
    $error("branch_predict_table: GHR_W must not exceed log2(ENTRIES)");
  end
  if (PC_W < IDX_W + 2) begin : g_bad_pc_w
    $error("branch_predict_table: PC_W too narrow for the table index");
  end

  logic [IDX_MAX_W-1:0] w_pred_pc_word;
  logic [IDX_MAX_W-1:0] w_upd_pc_word;
  logic [IDX_MAX_W-1:0] w_ghr_ext;
  logic [IDX_MAX_W-1:0] w_upd_ghr_ext;
  logic [IDX_MAX_W-1:0] w_pred_hash;
  logic [IDX_MAX_W-1:0] w_upd_hash;
  logic [IDX_W-1:0]     w_pred_idx;
  logic [IDX_W-1:0]     w_upd_idx;
  logic [ENTRIES-1:0]   w_cnt_taken;
  logic                 w_pred_dir;
  logic [GHR_WE-1:0]    r_ghr;
  logic                 r_pred_taken;
  logic                 r_pred_out_valid;
  logic [GHR_WE-1:0]    r_pred_ghr;
  logic                 w_unused;

  // Index generation: lookups hash with the live GHR, updates with the
  // snapshot that travelled down the pipe with the branch.
  always_comb begin
    w_pred_pc_word               = '0;
    w_upd_pc_word                = '0;
    w_ghr_ext                    = '0;
    w_upd_ghr_ext                = '0;
    w_pred_pc_word[IDX_W-1:0]    = pred_pc[IDX_W+1:2];
    w_upd_pc_word[IDX_W-1:0]     = upd_pc[IDX_W+1:2];
    if (GHR_W > 0) begin
      w_ghr_ext[GHR_WE-1:0]      = r_ghr;
      w_upd_ghr_ext[GHR_WE-1:0]  = upd_ghr;
    end
    w_pred_hash = idx_hash(w_pred_pc_word, w_ghr_ext, IDX_W);
    w_upd_hash  = idx_hash(w_upd_pc_word, w_upd_ghr_ext, IDX_W);
    w_pred_idx  = w_pred_hash[IDX_W-1:0];
    w_upd_idx   = w_upd_hash[IDX_W-1:0];
  end

  // Counter array; each entry sees the update only when it is the target.
  for (genvar g = 0; g < ENTRIES; g++) begin : g_cnt
    bp_sat_counter #(
      .CNT_W(CNT_W)
    ) u_cnt (
      .clk        (clk),
      .rstn       (rstn),
      .i_upd_en   (upd_valid && (w_upd_idx == IDX_W'(g))),
      .i_upd_taken(upd_taken),
      .o_taken    (w_cnt_taken[g])
    );
  end

  // Read mux sees the pre-update counter, giving read-before-write on collision.
  assign w_pred_dir = w_cnt_taken[w_pred_idx];

  if (GHR_W > 0) begin : g_ghr
    // Speculative history shift; mispredict recovery overrides the shift.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        r_ghr <= '0;
      end else if (upd_valid && upd_mispredict) begin
        r_ghr <= GHR_WE'({upd_ghr, upd_taken});
      end else if (pred_valid) begin
        r_ghr <= GHR_WE'({r_ghr, w_pred_dir});
      end
    end
  end else begin : g_no_ghr
    assign r_ghr = '0;
  end

  // Registered prediction outputs; direction and snapshot hold between lookups.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pred_taken     <= 1'b0;
      r_pred_out_valid <= 1'b0;
      r_pred_ghr       <= '0;
    end else begin
      r_pred_out_valid <= pred_valid;
      if (pred_valid) begin
        r_pred_taken <= w_pred_dir;
        r_pred_ghr   <= r_ghr;
      end
    end
  end

  assign pred_taken     = r_pred_taken;
  assign pred_out_valid = r_pred_out_valid;
  assign pred_ghr       = r_pred_ghr;

  // PC bits outside the index, hash bits above IDX_W, and history inputs in
  // the bimodal configuration are intentionally ignored.
  assign w_unused = ^{pred_pc, upd_pc, upd_ghr, upd_mispredict, w_pred_hash, w_upd_hash};

endmodule

// File: tb/tb_branch_predict_table.sv
// Directed bench for branch_predict_table: a bimodal 2-bit table, a bimodal
// 3-bit table and a 4-bit-history gshare table share one stimulus stream.
module tb_branch_predict_table;

  logic        clk;
  logic        rstn;
  logic        pred_valid;
  logic [31:0] pred_pc;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic [3:0]  upd_ghr;
  logic        upd_taken;
  logic        upd_mispredict;

  logic        bim_taken, bim_vld;
  logic [0:0]  bim_ghr;
  logic        c3_taken, c3_vld;
  logic [0:0]  c3_ghr;
  logic        gs_taken, gs_vld;
  logic [3:0]  gs_ghr;

  int checks;
  int errors;

  branch_predict_table #(.ENTRIES(64), .CNT_W(2), .GHR_W(0), .PC_W(32)) u_bim (
    .clk(clk), .rstn(rstn),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_taken(bim_taken), .pred_out_valid(bim_vld), .pred_ghr(bim_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr[0:0]),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict)
  );

  branch_predict_table #(.ENTRIES(64), .CNT_W(3), .GHR_W(0), .PC_W(32)) u_c3 (
    .clk(clk), .rstn(rstn),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_taken(c3_taken), .pred_out_valid(c3_vld), .pred_ghr(c3_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr[0:0]),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict)
  );

  branch_predict_table #(.ENTRIES(64), .CNT_W(2), .GHR_W(4), .PC_W(32)) u_gs (
    .clk(clk), .rstn(rstn),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_taken(gs_taken), .pred_out_valid(gs_vld), .pred_ghr(gs_ghr),
    .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply one cycle of inputs; on return the outputs reflect that cycle's lookup.
  task automatic drive(input logic pv, input logic [31:0] ppc,
                       input logic uv, input logic [31:0] upc, input logic [3:0] ug,
                       input logic ut, input logic um);
    pred_valid     = pv;
    pred_pc        = ppc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_ghr        = ug;
    upd_taken      = ut;
    upd_mispredict = um;
    tick();
  endtask

  task automatic do_reset();
    pred_valid     = 1'b0;
    upd_valid      = 1'b0;
    upd_mispredict = 1'b0;
    rstn           = 1'b0;
    tick();
    tick();
    rstn = 1'b1;
  endtask

  task automatic test_reset();
    rstn = 1'b1;
    pred_valid = 1'b0; pred_pc = '0;
    upd_valid = 1'b0; upd_pc = '0; upd_ghr = '0; upd_taken = 1'b0; upd_mispredict = 1'b0;
    #1;
    rstn = 1'b0;
    #2;
    checks++;
    if (bim_taken !== 1'b0 || bim_vld !== 1'b0 || bim_ghr !== 1'b0) begin
      errors++;
      $display("FAIL reset_bim_outputs got taken=%b vld=%b ghr=%b exp 0/0/0", bim_taken, bim_vld, bim_ghr);
    end
    checks++;
    if (gs_taken !== 1'b0 || gs_vld !== 1'b0 || gs_ghr !== 4'h0) begin
      errors++;
      $display("FAIL reset_gs_outputs got taken=%b vld=%b ghr=%h exp 0/0/0", gs_taken, gs_vld, gs_ghr);
    end
    tick();
    rstn = 1'b1;
    for (int pc = 0; pc <= 32'hFC; pc += 4) begin
      drive(1'b1, 32'(pc), 1'b0, '0, '0, 1'b0, 1'b0);
      checks++;
      if (bim_taken !== 1'b0 || bim_vld !== 1'b1) begin
        errors++;
        $display("FAIL reset_lookup pc=%0h got taken=%b vld=%b exp taken=0 vld=1", pc, bim_taken, bim_vld);
      end
    end
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (bim_vld !== 1'b0) begin
      errors++;
      $display("FAIL idle_valid got %b exp 0", bim_vld);
    end
    checks++;
    if (bim_ghr !== 1'b0) begin
      errors++;
      $display("FAIL bimodal_ghr_tied got %b exp 0", bim_ghr);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1, 32'h40, '0, 1'b1, 1'b0);
    drive(1'b1, 32'h40, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (bim_taken !== 1'b1) begin
      errors++;
      $display("FAIL sat_high_taken got %b exp 1", bim_taken);
    end
    // 0x140 aliases onto the same entry (same PC[7:2]); 0x44 is a neighbour.
    drive(1'b1, 32'h140, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (bim_taken !== 1'b1) begin
      errors++;
      $display("FAIL sat_alias got %b exp 1", bim_taken);
    end
    drive(1'b1, 32'h44, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (bim_taken !== 1'b0) begin
      errors++;
      $display("FAIL sat_neighbour got %b exp 0", bim_taken);
    end
    drive(1'b0, '0, 1'b1, 32'h40, '0, 1'b0, 1'b0);
    drive(1'b1, 32'h40, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (bim_taken !== 1'b1) begin
      errors++;
      $display("FAIL sat_after_one_nt got %b exp 1", bim_taken);
    end
    drive(1'b0, '0, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (bim_vld !== 1'b0 || bim_taken !== 1'b1) begin
      errors++;
      $display("FAIL hold_when_idle got vld=%b taken=%b exp vld=0 taken=1", bim_vld, bim_taken);
    end
    for (int i = 0; i < 5; i++) drive(1'b0, '0, 1'b1, 32'h40, '0, 1'b0, 1'b0);
    drive(1'b1, 32'h40, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (bim_taken !== 1'b0) begin
      errors++;
      $display("FAIL sat_low_nt got %b exp 0", bim_taken);
    end
    // From 0, one taken step reaches 1 (not-taken); a wrapped counter would not.
    drive(1'b0, '0, 1'b1, 32'h40, '0, 1'b1, 1'b0);
    drive(1'b1, 32'h40, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (bim_taken !== 1'b0) begin
      errors++;
      $display("FAIL sat_low_no_wrap got %b exp 0", bim_taken);
    end
  endtask

  task automatic test_cnt_w3();
    do_reset();
    drive(1'b1, 32'h10, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (c3_taken !== 1'b0 || c3_vld !== 1'b1 || c3_ghr !== 1'b0) begin
      errors++;
      $display("FAIL c3_reset_val got taken=%b vld=%b ghr=%b exp 0/1/0", c3_taken, c3_vld, c3_ghr);
    end
    drive(1'b0, '0, 1'b1, 32'h10, '0, 1'b1, 1'b0);
    drive(1'b1, 32'h10, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (c3_taken !== 1'b1) begin
      errors++;
      $display("FAIL c3_inc_to_4 got %b exp 1", c3_taken);
    end
    drive(1'b0, '0, 1'b1, 32'h10, '0, 1'b0, 1'b0);
    drive(1'b1, 32'h10, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (c3_taken !== 1'b0) begin
      errors++;
      $display("FAIL c3_dec_to_3 got %b exp 0", c3_taken);
    end
  endtask

  task automatic test_gshare();
    do_reset();
    // Train entries 0, 1 and 3 (PC 0 XOR snapshot) to weakly taken.
    drive(1'b0, '0, 1'b1, 32'h0, 4'h0, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 32'h0, 4'h1, 1'b1, 1'b0);
    drive(1'b0, '0, 1'b1, 32'h0, 4'h3, 1'b1, 1'b0);
    drive(1'b1, 32'h0, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (gs_taken !== 1'b1 || gs_ghr !== 4'h0 || gs_vld !== 1'b1) begin
      errors++;
      $display("FAIL gs_lookup1 got taken=%b ghr=%h vld=%b exp 1/0/1", gs_taken, gs_ghr, gs_vld);
    end
    drive(1'b1, 32'h0, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (gs_taken !== 1'b1 || gs_ghr !== 4'h1) begin
      errors++;
      $display("FAIL gs_lookup2 got taken=%b ghr=%h exp 1/1", gs_taken, gs_ghr);
    end
    drive(1'b1, 32'h0, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (gs_taken !== 1'b1 || gs_ghr !== 4'b0011) begin
      errors++;
      $display("FAIL gs_lookup3 got taken=%b ghr=%h exp 1/3", gs_taken, gs_ghr);
    end
    // Lookup with GHR=0111 (entry 7, untrained) alongside a mispredict recovery.
    drive(1'b1, 32'h0, 1'b1, 32'h0, 4'b0001, 1'b0, 1'b1);
    checks++;
    if (gs_taken !== 1'b0 || gs_ghr !== 4'b0111) begin
      errors++;
      $display("FAIL gs_recover_cycle got taken=%b ghr=%h exp 0/7", gs_taken, gs_ghr);
    end
    drive(1'b1, 32'h0, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (gs_taken !== 1'b0 || gs_ghr !== 4'b0010) begin
      errors++;
      $display("FAIL gs_recovered_ghr got taken=%b ghr=%h exp 0/2", gs_taken, gs_ghr);
    end
    drive(1'b1, 32'h0, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (gs_ghr !== 4'b0100) begin
      errors++;
      $display("FAIL gs_shift_not_taken got ghr=%h exp 4", gs_ghr);
    end
  endtask

  task automatic test_collision();
    do_reset();
    drive(1'b1, 32'h8, 1'b1, 32'h8, '0, 1'b1, 1'b0);
    checks++;
    if (bim_taken !== 1'b0 || bim_vld !== 1'b1) begin
      errors++;
      $display("FAIL collision_read_old got taken=%b vld=%b exp 0/1", bim_taken, bim_vld);
    end
    drive(1'b1, 32'h8, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (bim_taken !== 1'b1) begin
      errors++;
      $display("FAIL collision_write_applied got %b exp 1", bim_taken);
    end
  endtask

  task automatic test_back_to_back_reset();
    do_reset();
    drive(1'b1, 32'h40, 1'b1, 32'h40, '0, 1'b1, 1'b0);
    drive(1'b1, 32'h40, 1'b1, 32'h40, '0, 1'b1, 1'b0);
    drive(1'b1, 32'h40, 1'b1, 32'h80, '0, 1'b1, 1'b0);
    checks++;
    if (bim_taken !== 1'b1 || gs_ghr !== 4'h1) begin
      errors++;
      $display("FAIL b2b_pre_reset got bim_taken=%b gs_ghr=%h exp 1/1", bim_taken, gs_ghr);
    end
    // Keep traffic flowing and drop reset mid-cycle.
    pred_valid = 1'b1; pred_pc = 32'h40; upd_valid = 1'b1; upd_pc = 32'h40; upd_taken = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    checks++;
    if (bim_taken !== 1'b0 || bim_vld !== 1'b0 || gs_ghr !== 4'h0 || gs_vld !== 1'b0) begin
      errors++;
      $display("FAIL async_reset got bim_taken=%b bim_vld=%b gs_ghr=%h gs_vld=%b exp 0/0/0/0",
               bim_taken, bim_vld, gs_ghr, gs_vld);
    end
    tick();
    rstn = 1'b1;
    drive(1'b1, 32'h40, 1'b0, '0, '0, 1'b0, 1'b0);
    checks++;
    if (bim_taken !== 1'b0 || bim_vld !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_lookup got taken=%b vld=%b exp 0/1", bim_taken, bim_vld);
    end
    checks++;
    if (gs_ghr !== 4'h0 || gs_taken !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_ghr got ghr=%h taken=%b exp 0/0", gs_ghr, gs_taken);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_saturation();
    test_cnt_w3();
    test_gshare();
    test_collision();
    test_back_to_back_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
